imem_fetch_ctrl: RTL and testbench

Instruction-fetch controller sequencing the 64-word combinational instruction ROM (`imem`). It owns the ROM's single address port, generates sequential fetch addresses, and buffers fetched words in a small prefetch FIFO. It presents the words to decode with a valid/ready handshake, handles branch redirects with a flush, and time-shares the ROM with a debug read port without starving either side.

---
 rtl/imem_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 83 ++++++++
 rtl/imem_fetch_ctrl.sv | 170 +++++++++++++++++
 tb/tb_imem_fetch_ctrl.sv | 393 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-fetch slice.
//   IMEM_WORDS    : number of 32-bit words in the instruction ROM
//   fetch_state_t : fetch controller states (BOOT, RUN, HALT)
//   fetch_entry_t : one prefetch FIFO entry {pc, instr}
package imem_pkg;

   localparam int IMEM_WORDS = 64;

   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small prefetch FIFO holding {pc, instr} entries.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : synchronous clear; wins over push and pop
//   push/wdata : write an entry (accepted when not full, or full with a pop)
//   pop        : drop the head entry (ignored when empty)
//   full/empty : occupancy flags
//   head       : current head entry (contents undefined-but-stable when empty)
module fetch_fifo
   import imem_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         flush,
   input  logic         push,
   input  fetch_entry_t wdata,
   input  logic         pop,
   output logic         full,
   output logic         empty,
   output fetch_entry_t head
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   fetch_entry_t     mem_q [DEPTH];
   fetch_entry_t     mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             push_ok;
   logic             pop_ok;

   assign empty   = (count_q == '0);
   assign full    = (count_q == FULL_CNT);
   assign pop_ok  = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head    = mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: instruction-fetch controller for the 64-word combinational ROM.
// Owns the ROM address port, fetches sequentially into a prefetch FIFO, serves
// decode with valid/ready, flushes on redirect and time-shares the ROM with a
// debug read port (debug wins on idle fetch slots or after BURST fetches).
//
// Optional build macro: IMEM_FETCH_BOUNDS_EN -- a fetch at or beyond the ROM size
// pushes nothing, raises sticky fault and blocks fetching until a redirect.
// Without it fault stays 0 and fetch addresses alias through the ROM index bits.
//
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   imem_a / imem_rd              : ROM byte address out / combinational word in
//   halt                          : pause fetching (HALT state)
//   redirect_valid / redirect_pc  : branch redirect, flushes the FIFO
//   instr_valid/instr/instr_pc    : FIFO head toward decode
//   instr_ready                   : decode accepts head
//   dbg_req / dbg_addr            : debug read request, held until dbg_gnt
//   dbg_gnt                       : combinational grant (ROM serves dbg_addr now)
//   dbg_rdata / dbg_valid         : registered debug data, valid the cycle after grant
//   fault                         : sticky out-of-range fetch flag
//
// state | meaning
// BOOT  | one cycle after reset release, no fetch, no debug grant
// RUN   | fetching whenever the slot is free
// HALT  | no fetching, FIFO drains, debug served immediately
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter int          DEPTH    = 2,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          BURST    = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] imem_a,
   input  logic [31:0] imem_rd,
   input  logic        halt,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready,
   input  logic        dbg_req,
   input  logic [31:0] dbg_addr,
   output logic        dbg_gnt,
   output logic [31:0] dbg_rdata,
   output logic        dbg_valid,
   output logic        fault
);

   localparam int          SW         = $clog2(BURST + 1);
   localparam logic [SW-1:0] BURST_CNT = SW'(BURST);
   localparam logic [31:0] RESET_WPC  = {RESET_PC[31:2], 2'b00};

   fetch_state_t  state_q, state_d;
   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [SW-1:0] starve_q, starve_d;
   logic          fault_q, fault_d;
   logic          dbg_valid_q, dbg_valid_d;
   logic [31:0]   dbg_rdata_q, dbg_rdata_d;

   logic          fifo_full;
   logic          fifo_empty;
   fetch_entry_t  fifo_head;
   fetch_entry_t  push_entry;
   logic          pop;
   logic          slot_free;
   logic          gnt;
   logic          fetch_go;
   logic          oob;
   logic          push;
   logic          unused_ok;

   // Low address bits are architecturally ignored.
   assign unused_ok = ^{redirect_pc[1:0], dbg_addr[1:0]};

`ifdef IMEM_FETCH_BOUNDS_EN
   assign oob = (fetch_pc_q >= 32'(IMEM_WORDS * 4));
`else
   assign oob = 1'b0;
`endif

   assign pop       = !fifo_empty && instr_ready;
   // Slot availability ignoring debug; a full FIFO is fine if decode frees a spot.
   assign slot_free = (state_q == RUN) && !redirect_valid && (!fifo_full || pop) && !fault_q;
   // Debug takes idle slots for free, and steals a live slot once BURST fetches
   // have gone by with the request pending.
   assign gnt       = dbg_req && (state_q != BOOT) && (!slot_free || (starve_q == BURST_CNT));
   assign fetch_go  = slot_free && !gnt;
   assign push      = fetch_go && !oob;

   assign push_entry = '{pc: fetch_pc_q, instr: imem_rd};

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (push),
      .wdata (push_entry),
      .pop   (pop),
      .full  (fifo_full),
      .empty (fifo_empty),
      .head  (fifo_head)
   );

   assign imem_a      = gnt ? {dbg_addr[31:2], 2'b00} : fetch_pc_q;
   assign instr_valid = !fifo_empty;
   assign instr       = fifo_head.instr;
   assign instr_pc    = fifo_head.pc;
   assign dbg_gnt     = gnt;
   assign dbg_rdata   = dbg_rdata_q;
   assign dbg_valid   = dbg_valid_q;
   assign fault       = fault_q;

   always_comb begin
      state_d = state_q;
      case (state_q)
         BOOT:    state_d = RUN;
         RUN:     if (halt)  state_d = HALT;
         HALT:    if (!halt) state_d = RUN;
         default: state_d = BOOT;
      endcase

      fetch_pc_d = fetch_pc_q;
      if (redirect_valid) begin
         fetch_pc_d = {redirect_pc[31:2], 2'b00};
      end else if (push) begin
         fetch_pc_d = fetch_pc_q + 32'd4;
      end

      fault_d = fault_q;
      if (redirect_valid) begin
         fault_d = 1'b0;
      end else if (fetch_go && oob) begin
         fault_d = 1'b1;
      end

      starve_d = starve_q;
      if (!dbg_req || gnt) begin
         starve_d = '0;
      end else if (fetch_go) begin
         starve_d = starve_q + 1'b1;
      end

      dbg_valid_d = gnt;
      dbg_rdata_d = gnt ? imem_rd : dbg_rdata_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= BOOT;
         fetch_pc_q  <= RESET_WPC;
         starve_q    <= '0;
         fault_q     <= 1'b0;
         dbg_valid_q <= 1'b0;
         dbg_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         starve_q    <= starve_d;
         fault_q     <= fault_d;
         dbg_valid_q <= dbg_valid_d;
         dbg_rdata_q <= dbg_rdata_d;
      end
   end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: self-checking bench for imem_fetch_ctrl.
// ROM model: word k = 0x100 + k, indexed by imem_a[7:2].
// The expected decode stream lives in exp_q; a monitor pops it on each handshake.
module tb_imem_fetch_ctrl;

   logic        clk;
   logic        rst_n;
   logic [31:0] imem_a;
   logic [31:0] imem_rd;
   logic        halt;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready;
   logic        dbg_req;
   logic [31:0] dbg_addr;
   logic        dbg_gnt;
   logic [31:0] dbg_rdata;
   logic        dbg_valid;
   logic        fault;

   int errors    = 0;
   int checks    = 0;
   int delivered = 0;
   logic [63:0] exp_q [$];

   imem_fetch_ctrl #(
      .DEPTH    (2),
      .RESET_PC (32'h0000_0000),
      .BURST    (4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_a         (imem_a),
      .imem_rd        (imem_rd),
      .halt           (halt),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_ready    (instr_ready),
      .dbg_req        (dbg_req),
      .dbg_addr       (dbg_addr),
      .dbg_gnt        (dbg_gnt),
      .dbg_rdata      (dbg_rdata),
      .dbg_valid      (dbg_valid),
      .fault          (fault)
   );

   assign imem_rd = 32'h100 + {26'd0, imem_a[7:2]};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
      $fatal(1);
   end

   // Scoreboard consumer: every accepted head must match the next expected entry.
   always @(negedge clk) begin
      if (rst_n && instr_valid && instr_ready && !redirect_valid) begin
         logic [63:0] e;
         checks++;
         delivered++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL stream_extra: got pc=%h instr=%h, required no delivery", instr_pc, instr);
         end else begin
            e = exp_q.pop_front();
            if ({instr_pc, instr} !== e) begin
               errors++;
               $display("FAIL stream: got pc=%h instr=%h, required pc=%h instr=%h",
                        instr_pc, instr, e[63:32], e[31:0]);
            end
         end
      end
   end

   task automatic exp_fill(input logic [31:0] start, input int n);
      logic [31:0] pc;
      pc = start;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({pc, 32'h100 + {26'd0, pc[7:2]}});
         pc = pc + 32'd4;
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst_n          = 1'b0;
      halt           = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      instr_ready    = 1'b1;
      dbg_req        = 1'b0;
      dbg_addr       = '0;
      exp_q.delete();
      exp_fill(32'h0, 100);
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({instr_valid, instr, instr_pc, dbg_gnt, dbg_valid, dbg_rdata, fault} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got valid=%b instr=%h pc=%h gnt=%b dval=%b drd=%h fault=%b, required all 0",
                  instr_valid, instr, instr_pc, dbg_gnt, dbg_valid, dbg_rdata, fault);
      end
      checks++;
      if (imem_a !== 32'h0) begin
         errors++;
         $display("FAIL reset_imem_a: got %h, required 00000000", imem_a);
      end
      tick;
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || dbg_gnt !== 1'b0) begin
         errors++;
         $display("FAIL boot_cycle: got valid=%b gnt=%b, required 0 0", instr_valid, dbg_gnt);
      end
      tick;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0 || imem_a !== 32'h0) begin
         errors++;
         $display("FAIL first_fetch: got valid=%b imem_a=%h, required 0 00000000", instr_valid, imem_a);
      end
      tick;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== 32'h100) begin
         errors++;
         $display("FAIL first_valid: got valid=%b pc=%h instr=%h, required 1 00000000 00000100",
                  instr_valid, instr_pc, instr);
      end
      tick;
   endtask

   task automatic test_stream;
      int d0;
      d0 = delivered;
      repeat (10) begin
         @(negedge clk);
         tick;
      end
      checks++;
      if (delivered - d0 != 10) begin
         errors++;
         $display("FAIL throughput: got %0d deliveries in 10 cycles, required 10", delivered - d0);
      end
   endtask

   task automatic test_stall;
      logic [31:0] a_prev;
      instr_ready = 1'b0;
      a_prev = '0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (i >= 2) begin
            checks++;
            if (imem_a !== a_prev || imem_a !== instr_pc + 32'd8 || instr_valid !== 1'b1) begin
               errors++;
               $display("FAIL stall_hold: got imem_a=%h head_pc=%h valid=%b, required imem_a=%h head_pc+8 valid=1",
                        imem_a, instr_pc, instr_valid, a_prev);
            end
         end
         a_prev = imem_a;
         tick;
      end
      instr_ready = 1'b1;
      repeat (6) tick;
   endtask

   task automatic test_redirect;
      instr_ready = 1'b0;
      repeat (3) tick;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h23;
      instr_ready    = 1'b1;
      exp_q.delete();
      exp_fill(32'h20, 100);
      tick;
      redirect_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL redirect_bubble: got valid=%b, required 0", instr_valid);
      end
      tick;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h20 || instr !== 32'h108) begin
         errors++;
         $display("FAIL redirect_target: got valid=%b pc=%h instr=%h, required 1 00000020 00000108",
                  instr_valid, instr_pc, instr);
      end
      tick;
   endtask

   task automatic test_debug;
      int waited;
      logic found;
      logic [31:0] a_gnt;
      repeat (2) tick;
      dbg_req  = 1'b1;
      dbg_addr = 32'h10;
      found    = 1'b0;
      waited   = 0;
      a_gnt    = '0;
      for (int i = 1; i <= 8; i++) begin
         @(negedge clk);
         if (dbg_gnt === 1'b1) begin
            found  = 1'b1;
            waited = i;
            a_gnt  = imem_a;
            break;
         end
         tick;
      end
      checks++;
      if (!found || waited != 5 || a_gnt !== 32'h10) begin
         errors++;
         $display("FAIL dbg_grant: got found=%b wait=%0d imem_a=%h, required 1 5 00000010",
                  found, waited, a_gnt);
      end
      tick;
      dbg_req = 1'b0;
      @(negedge clk);
      checks++;
      if (dbg_valid !== 1'b1 || dbg_rdata !== 32'h104) begin
         errors++;
         $display("FAIL dbg_data: got dval=%b rdata=%h, required 1 00000104", dbg_valid, dbg_rdata);
      end
      tick;
      @(negedge clk);
      checks++;
      if (dbg_valid !== 1'b0) begin
         errors++;
         $display("FAIL dbg_pulse: got dval=%b, required 0", dbg_valid);
      end
      repeat (4) tick;
   endtask

   task automatic test_halt;
      logic [31:0] a_prev;
      int d0;
      halt = 1'b1;
      repeat (4) tick;
      @(negedge clk);
      a_prev = imem_a;
      d0 = delivered;
      checks++;
      if (instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_drain: got valid=%b, required 0", instr_valid);
      end
      repeat (2) tick;
      @(negedge clk);
      checks++;
      if (imem_a !== a_prev || delivered != d0 || instr_valid !== 1'b0) begin
         errors++;
         $display("FAIL halt_nofetch: got imem_a=%h deliveries=%0d valid=%b, required %h 0 0",
                  imem_a, delivered - d0, instr_valid, a_prev);
      end
      tick;
      dbg_req  = 1'b1;
      dbg_addr = 32'h43;
      @(negedge clk);
      checks++;
      if (dbg_gnt !== 1'b1 || imem_a !== 32'h40) begin
         errors++;
         $display("FAIL halt_dbg_gnt: got gnt=%b imem_a=%h, required 1 00000040", dbg_gnt, imem_a);
      end
      tick;
      dbg_req = 1'b0;
      halt    = 1'b0;
      @(negedge clk);
      checks++;
      if (dbg_valid !== 1'b1 || dbg_rdata !== 32'h110) begin
         errors++;
         $display("FAIL halt_dbg_data: got dval=%b rdata=%h, required 1 00000110", dbg_valid, dbg_rdata);
      end
      repeat (6) tick;
   endtask

   task automatic test_bounds;
      logic exp_fault;
`ifdef IMEM_FETCH_BOUNDS_EN
      exp_fault = 1'b1;
`else
      exp_fault = 1'b0;
`endif
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFC;
      exp_q.delete();
      exp_fill(32'hFC, exp_fault ? 1 : 100);
      tick;
      redirect_valid = 1'b0;
      tick;
      @(negedge clk);
      checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'hFC || instr !== 32'h13F) begin
         errors++;
         $display("FAIL bounds_last_word: got valid=%b pc=%h instr=%h, required 1 000000fc 0000013f",
                  instr_valid, instr_pc, instr);
      end
      tick;
      @(negedge clk);
      checks++;
      if (fault !== exp_fault) begin
         errors++;
         $display("FAIL bounds_fault: got %b, required %b", fault, exp_fault);
      end
      repeat (3) tick;
      @(negedge clk);
      checks++;
      if (fault !== exp_fault || instr_valid !== !exp_fault) begin
         errors++;
         $display("FAIL bounds_blocked: got fault=%b valid=%b, required %b %b",
                  fault, instr_valid, exp_fault, !exp_fault);
      end
      tick;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0;
      exp_q.delete();
      exp_fill(32'h0, 100);
      tick;
      redirect_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (fault !== 1'b0) begin
         errors++;
         $display("FAIL bounds_clear: got fault=%b, required 0", fault);
      end
      repeat (4) tick;
   endtask

   task automatic test_reset_mid;
      halt = 1'b1;
      repeat (3) tick;
      dbg_req  = 1'b1;
      dbg_addr = 32'h8;
      @(negedge clk);
      checks++;
      if (dbg_gnt !== 1'b1) begin
         errors++;
         $display("FAIL mid_gnt: got gnt=%b, required 1", dbg_gnt);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (dbg_gnt !== 1'b0 || instr_valid !== 1'b0 || imem_a !== 32'h0) begin
         errors++;
         $display("FAIL mid_async: got gnt=%b valid=%b imem_a=%h, required 0 0 00000000",
                  dbg_gnt, instr_valid, imem_a);
      end
      tick;
      checks++;
      if (dbg_valid !== 1'b0 || dbg_rdata !== 32'h0) begin
         errors++;
         $display("FAIL mid_dbg_drop: got dval=%b rdata=%h, required 0 00000000", dbg_valid, dbg_rdata);
      end
      dbg_req = 1'b0;
      halt    = 1'b0;
      exp_q.delete();
      exp_fill(32'h0, 100);
      rst_n = 1'b1;
      repeat (6) tick;
   endtask

   initial begin
      test_reset;
      test_stream;
      test_stall;
      test_redirect;
      test_debug;
      test_halt;
      test_bounds;
      test_reset_mid;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
